// File: rtl/ahblite_busmatrix_arbiter_rr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_bm_pkg
// Description : Shared AHB-Lite encodings, lock-state type and burst helper
//               for the bus-matrix output-stage arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_bm_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  typedef enum logic [1:0] {
    UNLOCKED   = 2'd0,
    LOCK_FIXED = 2'd1,
    LOCK_INCR  = 2'd2
  } lock_state_e;

  // Remaining beats after the NONSEQ beat; zero for SINGLE and undefined INCR.
  function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
    logic [3:0] beats;
    beats = 4'd0;
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  beats = 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  beats = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: beats = 4'd15;
      default:                      beats = 4'd0;
    endcase
    return beats;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahblite_busmatrix_arbiter_rr_if.sv
`default_nettype none
// ============================================================================
// Module      : ahblite_busmatrix_arbiter_rr_if
// Description : Request / output-stage status inputs and grant outputs of
//               one output-stage arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface ahblite_busmatrix_arbiter_rr_if #(
  parameter int NUM_PORTS = 4
);
  localparam int SEL_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0] REQ;
  logic                 HREADY_Outputstage;
  logic                 HSEL_Outputstage;
  logic [1:0]           HTRANS_Outputstage;
  logic [2:0]           HBURST_Outputstage;
  logic [SEL_W-1:0]     PORT_SEL_ARBITER;
  logic                 PORT_NOSEL_ARBITER;
  logic                 PORT_LOCKED;

  modport master (
    output REQ, HREADY_Outputstage, HSEL_Outputstage,
           HTRANS_Outputstage, HBURST_Outputstage,
    input  PORT_SEL_ARBITER, PORT_NOSEL_ARBITER, PORT_LOCKED
  );

  modport slave (
    input  REQ, HREADY_Outputstage, HSEL_Outputstage,
           HTRANS_Outputstage, HBURST_Outputstage,
    output PORT_SEL_ARBITER, PORT_NOSEL_ARBITER, PORT_LOCKED
  );
endinterface
`default_nettype wire

// File: rtl/ahblite_busmatrix_arbiter_rr_burst_tracker.sv
`default_nettype none
// ============================================================================
// Module      : ahblite_arb_burst_tracker
// Description : Burst lock FSM and beat counter; tells the arbiter when a
//               lock starts, when it ends and whether it is held.
// Revision    : 1.0 - initial release
// ============================================================================
module ahblite_arb_burst_tracker
  import ahb_bm_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hready,
  input  logic       hsel,
  input  logic [1:0] htrans,
  input  logic [2:0] hburst,
  input  logic       owner_req,
  output logic       locked,
  output logic       lock_start,
  output logic       release_now
);

  lock_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lock_start  = 1'b0;
    release_now = 1'b0;
    case (state_q)
      UNLOCKED: begin
        if (hsel && (htrans == HTRANS_NONSEQ)) begin
          if (hburst == HBURST_INCR) begin
            state_d    = LOCK_INCR;
            lock_start = 1'b1;
          end else if (hburst != HBURST_SINGLE) begin
            state_d    = LOCK_FIXED;
            cnt_d      = CNT_W'(burst_beats(hburst));
            lock_start = 1'b1;
          end
        end
      end
      LOCK_FIXED: begin
        // BUSY keeps the count; IDLE/NONSEQ is an early termination.
        if (htrans == HTRANS_SEQ && cnt_q > CNT_W'(1)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (htrans != HTRANS_BUSY) begin
          state_d     = UNLOCKED;
          cnt_d       = '0;
          release_now = 1'b1;
        end
      end
      LOCK_INCR: begin
        if (!(owner_req && (htrans == HTRANS_SEQ || htrans == HTRANS_BUSY))) begin
          state_d     = UNLOCKED;
          cnt_d       = '0;
          release_now = 1'b1;
        end
      end
      default: begin
        state_d = UNLOCKED;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNLOCKED;
      cnt_q   <= '0;
    end else if (hready) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign locked = (state_q != UNLOCKED);

endmodule
`default_nettype wire

// File: rtl/ahblite_busmatrix_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : ahblite_busmatrix_arbiter_rr
// Description : N-port output-stage arbiter with burst locking. Define
//               ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module ahblite_busmatrix_arbiter_rr
  import ahb_bm_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int CNT_W     = 4
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  ahblite_busmatrix_arbiter_rr_if.slave bus
);

  localparam int SEL_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0] req;
  logic                 hready;
  logic                 req_any;
  logic                 owner_req;
  logic                 locked, lock_start, release_now;
  logic                 arb_en;
  logic [SEL_W-1:0]     winner;
  logic [SEL_W-1:0]     selport_q, selport_d;
  logic                 noport_q, noport_d;

  assign req       = bus.REQ;
  assign hready    = bus.HREADY_Outputstage;
  assign req_any   = |req;
  assign owner_req = req[selport_q];

  ahblite_arb_burst_tracker #(
    .CNT_W (CNT_W)
  ) u_burst_tracker (
    .clk         (HCLK),
    .rst_n       (HRESETn),
    .hready      (hready),
    .hsel        (bus.HSEL_Outputstage),
    .htrans      (bus.HTRANS_Outputstage),
    .hburst      (bus.HBURST_Outputstage),
    .owner_req   (owner_req),
    .locked      (locked),
    .lock_start  (lock_start),
    .release_now (release_now)
  );

  // The NONSEQ that opens a burst belongs to the current owner, so that edge keeps the grant.
  assign arb_en = release_now | (~locked & ~lock_start);

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic [SEL_W:0] NP_W = (SEL_W+1)'(NUM_PORTS);

  logic [SEL_W-1:0] last_q, last_d;

  always_comb begin
    logic           found;
    logic [SEL_W:0] pos;
    found  = 1'b0;
    pos    = '0;
    winner = last_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      pos = {1'b0, last_q} + (SEL_W+1)'(i + 1);
      if (pos >= NP_W) pos = pos - NP_W;
      if (!found && req[pos[SEL_W-1:0]]) begin
        found  = 1'b1;
        winner = pos[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (arb_en && req_any) last_d = winner;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      last_q <= SEL_W'(NUM_PORTS - 1);
    end else if (hready) begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[i]) winner = SEL_W'(i);
    end
  end
`endif

  always_comb begin
    selport_d = selport_q;
    noport_d  = noport_q;
    if (arb_en) begin
      noport_d = ~req_any & ~bus.HSEL_Outputstage;
      if (req_any) selport_d = winner;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      selport_q <= '0;
      noport_q  <= 1'b1;
    end else if (hready) begin
      selport_q <= selport_d;
      noport_q  <= noport_d;
    end
  end

  assign bus.PORT_SEL_ARBITER   = selport_q;
  assign bus.PORT_NOSEL_ARBITER = noport_q;
  assign bus.PORT_LOCKED        = locked;

endmodule
`default_nettype wire
